// File: rtl/obstacle_row_scheduler_if.sv
// Bus between the frame/game control side and the obstacle row scheduler.
interface obstacle_row_scheduler_if #(
    parameter int unsigned NUM_ROWS = 6
);
    logic                          frame_tick;
    logic [1:0]                    state;
    logic                          cfg_we;
    logic [2:0]                    cfg_row;
    logic                          cfg_dir;
    logic [2:0]                    cfg_speed;
    logic [NUM_ROWS-1:0][9:0]      row_offset;
    logic                          update_busy;
    logic                          update_done;
    logic                          overrun;

    modport master (
        output frame_tick, state, cfg_we, cfg_row, cfg_dir, cfg_speed,
        input  row_offset, update_busy, update_done, overrun
    );

    modport slave (
        input  frame_tick, state, cfg_we, cfg_row, cfg_dir, cfg_speed,
        output row_offset, update_busy, update_done, overrun
    );
endinterface

// File: rtl/obstacle_row_scheduler.sv
// Per-frame scroll offset update for all obstacle rows, one row per clock
// through a single shared add/wrap unit.
module obstacle_row_scheduler #(
    parameter int unsigned NUM_ROWS = 6,
    parameter int unsigned SCREEN_W = 640
) (
    input  logic                    clk,
    input  logic                    reset,
    obstacle_row_scheduler_if.slave bus
);
    localparam int unsigned OFF_W = 10;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned SPD_W = 3;

    localparam logic [OFF_W-1:0] SCREEN_W_V = OFF_W'(SCREEN_W);
    localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(NUM_ROWS - 1);
    localparam logic [1:0]       GS_START   = 2'b00;
    localparam logic [1:0]       GS_PLAYING = 2'b01;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } fsm_t;

    fsm_t                           fsm_q;
    logic [IDX_W-1:0]               idx_q;
    logic [NUM_ROWS-1:0][OFF_W-1:0] offset_q;
    logic [NUM_ROWS-1:0]            dir_q;
    logic [NUM_ROWS-1:0][SPD_W-1:0] speed_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           overrun_q;

    logic [OFF_W-1:0] cur_off;
    logic [OFF_W-1:0] cur_spd;
    logic [OFF_W-1:0] span;
    logic             cur_dir;
    logic [OFF_W-1:0] nxt_off;

    // Shared add/wrap unit; span = SCREEN_W - s keeps every term within 10 bits.
    always_comb begin
        cur_off = offset_q[idx_q];
        cur_dir = dir_q[idx_q];
        cur_spd = OFF_W'(speed_q[idx_q]);
        span    = SCREEN_W_V - cur_spd;
        nxt_off = cur_off;
        if (!cur_dir) begin
            nxt_off = (cur_off >= span) ? (cur_off - span) : (cur_off + cur_spd);
        end else begin
            nxt_off = (cur_off >= cur_spd) ? (cur_off - cur_spd) : (cur_off + span);
        end
    end

    // Sweep FSM, speed configuration, game-state gating and overrun tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q     <= IDLE;
            idx_q     <= '0;
            offset_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int r = 0; r < int'(NUM_ROWS); r++) begin
                dir_q[r]   <= r[0];
                speed_q[r] <= SPD_W'((r % 3) + 1);
            end
        end else begin
            // The arithmetic above reads the pre-write value, so a write to the
            // row in flight only takes effect on the next frame.
            if (bus.cfg_we && (int'(bus.cfg_row) < int'(NUM_ROWS))) begin
                dir_q[bus.cfg_row]   <= bus.cfg_dir;
                speed_q[bus.cfg_row] <= bus.cfg_speed;
            end

            if (bus.frame_tick && (fsm_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            if (bus.state == GS_START) begin
                fsm_q    <= IDLE;
                idx_q    <= '0;
                offset_q <= '0;
                busy_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                case (fsm_q)
                    IDLE: begin
                        done_q <= 1'b0;
                        if (bus.frame_tick && (bus.state == GS_PLAYING)) begin
                            fsm_q  <= UPDATE;
                            idx_q  <= '0;
                            busy_q <= 1'b1;
                        end
                    end
                    UPDATE: begin
                        offset_q[idx_q] <= nxt_off;
                        idx_q           <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_ROW) begin
                            fsm_q  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        fsm_q  <= IDLE;
                        done_q <= 1'b0;
                    end
                    default: begin
                        fsm_q  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.row_offset  = offset_q;
    assign bus.update_busy = busy_q;
    assign bus.update_done = done_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_obstacle_row_scheduler.sv
// Scoreboard bench for obstacle_row_scheduler: each accepted frame pushes the
// modelled offsets, each update_done pops and compares them.
module tb_obstacle_row_scheduler;
    localparam int unsigned NUM_ROWS = 6;
    localparam int unsigned SCREEN_W = 640;

    localparam int EV_NONE  = 0;
    localparam int EV_START = 1;
    localparam int EV_OVER  = 2;
    localparam int EV_CFG   = 3;
    localparam int EV_TICK  = 4;

    typedef logic [NUM_ROWS-1:0][9:0] offs_t;

    logic clk;
    logic reset;

    obstacle_row_scheduler_if #(.NUM_ROWS(NUM_ROWS)) bus ();

    obstacle_row_scheduler #(
        .NUM_ROWS (NUM_ROWS),
        .SCREEN_W (SCREEN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    offs_t               m_off;
    logic [NUM_ROWS-1:0] m_dir;
    logic [2:0]          m_spd [NUM_ROWS];
    offs_t               sb_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference step: signed displacement reduced modulo the screen width.
    function automatic logic [9:0] adv(input logic [9:0] o, input logic d, input logic [2:0] s);
        int v;
        v = int'(o) + (d ? -int'(s) : int'(s));
        v = (v + int'(SCREEN_W)) % int'(SCREEN_W);
        return 10'(v);
    endfunction

    task automatic model_reset();
        m_off = '0;
        for (int r = 0; r < int'(NUM_ROWS); r++) begin
            m_dir[r] = r[0];
            m_spd[r] = 3'((r % 3) + 1);
        end
    endtask

    task automatic cfg_write(input int row, input logic d, input logic [2:0] s);
        bus.cfg_we    = 1'b1;
        bus.cfg_row   = 3'(row);
        bus.cfg_dir   = d;
        bus.cfg_speed = s;
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        if (row < int'(NUM_ROWS)) begin
            m_dir[row] = d;
            m_spd[row] = s;
        end
    endtask

    task automatic check_all(input string tag, input offs_t exp);
        for (int r = 0; r < int'(NUM_ROWS); r++)
            check($sformatf("%s_row%0d", tag, r), bus.row_offset[r], exp[r]);
    endtask

    task automatic start_clear();
        bus.state = 2'b00;
        @(posedge clk); #1;
        m_off = '0;
        check_all("start_clear", m_off);
        bus.state = 2'b01;
    endtask

    // One frame_tick in cycle T; optional event injected in cycle T+ev_k.
    task automatic do_frame(input int ev_k, input int ev_kind);
        offs_t nxt;
        bit    aborted;
        aborted = (ev_kind == EV_START);
        for (int r = 0; r < int'(NUM_ROWS); r++)
            nxt[r] = adv(m_off[r], m_dir[r], m_spd[r]);
        if (!aborted) sb_q.push_back(nxt);
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        for (int k = 1; k <= int'(NUM_ROWS) + 1; k++) begin
            if (k == ev_k) begin
                case (ev_kind)
                    EV_START: bus.state = 2'b00;
                    EV_OVER:  bus.state = 2'b10;
                    EV_CFG: begin
                        bus.cfg_we    = 1'b1;
                        bus.cfg_row   = 3'd2;
                        bus.cfg_dir   = 1'b1;
                        bus.cfg_speed = 3'd5;
                    end
                    EV_TICK:  bus.frame_tick = 1'b1;
                    default: ;
                endcase
            end
            if (aborted && k > ev_k) begin
                check($sformatf("abort_busy_k%0d", k), bus.update_busy, 0);
                check($sformatf("abort_done_k%0d", k), bus.update_done, 0);
                if (k == ev_k + 1) check_all("abort_clear", '0);
            end else begin
                check($sformatf("busy_k%0d", k), bus.update_busy, (k <= int'(NUM_ROWS)) ? 1 : 0);
                check($sformatf("done_k%0d", k), bus.update_done, (k == int'(NUM_ROWS) + 1) ? 1 : 0);
                if (k >= 2)
                    check($sformatf("row%0d_visible", k - 2), bus.row_offset[k-2], nxt[k-2]);
            end
            @(posedge clk); #1;
            if (k == ev_k) begin
                bus.cfg_we     = 1'b0;
                bus.frame_tick = 1'b0;
            end
        end
        check("idle_busy", bus.update_busy, 0);
        check("idle_done", bus.update_done, 0);
        m_off = aborted ? offs_t'('0) : nxt;
        if (ev_kind == EV_CFG) begin
            m_dir[2] = 1'b1;
            m_spd[2] = 3'd5;
        end
        bus.state = 2'b01;
    endtask

    // Scoreboard consumer: every update_done must match a pending frame.
    always @(negedge clk) begin
        if (!reset && bus.update_done) begin
            check("sb_pending", (sb_q.size() != 0) ? 1 : 0, 1);
            if (sb_q.size() != 0) begin
                offs_t e;
                e = sb_q.pop_front();
                for (int r = 0; r < int'(NUM_ROWS); r++)
                    check($sformatf("sb_row%0d", r), bus.row_offset[r], e[r]);
            end
        end
    end

    initial begin
        logic [9:0] prev2;
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        bus.state      = 2'b01;
        bus.cfg_we     = 1'b0;
        bus.cfg_row    = 3'd0;
        bus.cfg_dir    = 1'b0;
        bus.cfg_speed  = 3'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", '0);
        check("reset_busy", bus.update_busy, 0);
        check("reset_done", bus.update_done, 0);
        check("reset_overrun", bus.overrun, 0);
        reset = 1'b0;

        // Reset speeds: 1, 638, 3, 639, 2, 637 after one frame.
        do_frame(0, EV_NONE);
        check("dflt_row0", bus.row_offset[0], 1);
        check("dflt_row1", bus.row_offset[1], 638);
        check("dflt_row2", bus.row_offset[2], 3);
        check("dflt_row3", bus.row_offset[3], 639);
        check("dflt_row4", bus.row_offset[4], 2);
        check("dflt_row5", bus.row_offset[5], 637);

        // Forward wrap: row 0 at speed 7 walks 0 -> 637 -> 4.
        cfg_write(0, 1'b0, 3'd7);
        start_clear();
        for (int f = 0; f < 91; f++) do_frame(0, EV_NONE);
        check("fwd_pre", bus.row_offset[0], 637);
        do_frame(0, EV_NONE);
        check("fwd_wrap", bus.row_offset[0], 4);

        // Zero speed leaves a row still.
        cfg_write(3, 1'b1, 3'd0);
        do_frame(0, EV_NONE);

        // Freeze in OVER, then clear in START.
        bus.state      = 2'b10;
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("over_busy", bus.update_busy, 0);
            @(posedge clk); #1;
        end
        check_all("over_frozen", m_off);
        check("over_overrun", bus.overrun, 0);
        start_clear();

        // Abort by START mid-sweep, then OVER mid-sweep completes.
        do_frame(1, EV_NONE);
        do_frame(3, EV_START);
        check("abort_overrun", bus.overrun, 0);
        do_frame(3, EV_OVER);

        // Overrun from a second tick during the sweep.
        do_frame(4, EV_TICK);
        check("overrun_set", bus.overrun, 1);
        repeat (3) begin
            @(posedge clk); #1;
            check("overrun_one_sweep", bus.update_busy, 0);
        end

        // Config collision on row 2, then an out-of-range write.
        prev2 = m_off[2];
        do_frame(3, EV_CFG);
        check("cfg_old_speed", bus.row_offset[2], adv(prev2, 1'b0, 3'd3));
        prev2 = m_off[2];
        do_frame(0, EV_NONE);
        check("cfg_new_speed", bus.row_offset[2], adv(prev2, 1'b1, 3'd5));
        cfg_write(7, 1'b1, 3'd0);
        do_frame(0, EV_NONE);
        check("overrun_hold", bus.overrun, 1);

        // Only reset clears overrun.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("overrun_clear", bus.overrun, 0);
        check_all("final_reset", '0);
        check("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
